imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, meaning the instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 The module SHALL have parameter END_WORD, default 32'hFFFF_FFFF, meaning the program terminator word.
REQ-003 The module SHALL have port clk  input  1  the single system clock, rising-edge active.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 The module SHALL have port in_valid  input  1  the source presents a program word.
REQ-007 The module SHALL have port in_data  input  32  the program word.
REQ-008 The module SHALL have port in_ready  output  1  the loader accepts a word this cycle.
REQ-009 The module SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 The module SHALL have port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 The module SHALL have port imem_wdata  output  32  instruction-memory write data.
REQ-012 The module SHALL have port cpu_rst  output  1  active-high reset driven to the mips core.
REQ-013 The module SHALL have port busy  output  1  a load is in progress.
REQ-014 The module SHALL have port done  output  1  the load is complete and the core is running.
REQ-015 The module SHALL have port overflow  output  1  memory filled with no terminator received.
REQ-016 The module SHALL have port word_count  output  ADDR_W+1  number of words written in the last or current load, terminator included.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, PAD and RUN, with IDLE->LOAD on start, LOAD->PAD or RUN on terminator or full, PAD->RUN on wrap, and RUN->LOAD on start.
REQ-018 In IDLE and LOAD, cpu_rst SHALL be 1; in RUN, cpu_rst SHALL be 0; busy SHALL be 1 exactly in LOAD and PAD.
REQ-019 On entry to LOAD, the internal address and word_count SHALL clear to 0, and done and overflow SHALL clear to 0.
REQ-020 in_ready SHALL be 1 only in LOAD, and a word SHALL be accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-021 Writes SHALL have 1-cycle latency: the cycle after an acceptance, imem_we=1, imem_addr=the accept address, imem_wdata=the accepted word; otherwise imem_we=0.
REQ-022 Each acceptance SHALL increment the address (mod 2^ADDR_W) and increment word_count.
REQ-023 An accepted word equal to END_WORD SHALL be written and SHALL end LOAD.
REQ-024 A non-terminator word accepted at address 2^ADDR_W-1 SHALL set overflow=1 and end LOAD; the address SHALL wrap to 0 and no further words SHALL be accepted.
REQ-025 On entry to RUN, done SHALL be 1 and SHALL stay 1 until the next LOAD.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 start in RUN SHALL re-enter LOAD and raise cpu_rst on the next cycle.
REQ-028 in_valid outside LOAD SHALL be ignored with no write and no count change.

Reset
REQ-029 While rst=0, the module SHALL immediately force state=IDLE, cpu_rst=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, overflow=0 and word_count=0, independent of clk.
REQ-030 A reset asserted mid-LOAD or mid-PAD SHALL abort the load with no further writes; any partial memory contents SHALL be left as written.

Configuration
REQ-031 With macro IMEM_LOADER_PAD_EN defined, a terminator-ended LOAD SHALL enter PAD, which writes END_WORD on one word per cycle from the address after the terminator up to 2^ADDR_W-1 (imem_we=1 each cycle, word_count not incremented) and then enters RUN.
REQ-032 With IMEM_LOADER_PAD_EN defined, a terminator written at the last address, or an overflow, SHALL go straight to RUN.
REQ-033 With IMEM_LOADER_PAD_EN not defined, the PAD state SHALL NOT exist, and LOAD SHALL go directly to RUN.

Verification
REQ-034 Reset low for 3 ns with clk toggling -> all outputs at reset values, with cpu_rst=1 asynchronously.
REQ-035 start, then 7 words 32'h0082_1020 then 32'hFFFF_FFFF, valid every cycle -> writes addr 0..7 at 1-cycle lag, word_count=8, then done=1 and cpu_rst=0.
REQ-036 Same program with in_valid toggled every other cycle -> identical memory contents, with no write on idle cycles.
REQ-037 ADDR_W=3, 8 words without a terminator -> overflow=1, word_count=8, 8 writes, done=1.
REQ-038 With IMEM_LOADER_PAD_EN and ADDR_W=4, terminator at addr 3 -> END_WORD written to addr 4..15, then RUN; without the macro -> RUN directly after the addr 3 write.
REQ-039 rst pulsed low after the 3rd accepted word -> immediate IDLE with cpu_rst=1; a subsequent start reloads from addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//   Streams a program from a valid/ready source into instruction memory
//   while holding the core in reset, then releases the core.
//   A load starts on a one-cycle start pulse from IDLE or RUN. Each accepted
//   word is written one cycle later at consecutive word addresses. The load
//   ends on the terminator word (END_WORD, which is itself written) or when
//   the last address has been written without a terminator (overflow).
//
//   Optional feature, macro IMEM_LOADER_PAD_EN: after a terminator that is
//   not at the last address, a PAD state fills the rest of memory with
//   END_WORD, one word per cycle, before the core is released.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   start       one-cycle load request (ignored while busy)
//   in_valid    source presents in_data
//   in_data     program word
//   in_ready    loader accepts a word this cycle (LOAD only)
//   imem_we     memory write strobe
//   imem_addr   memory word address
//   imem_wdata  memory write data
//   cpu_rst     active-high core reset, low only in RUN
//   busy        load (or pad) in progress
//   done        load complete, core running
//   overflow    memory filled without a terminator
//   word_count  words written by the last/current load, terminator included
module imem_loader #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] END_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

`ifdef IMEM_LOADER_PAD_EN
    typedef enum logic [1:0] {IDLE, LOAD, PAD, RUN} state_e;
`else
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;
`endif

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;      // address the next word goes to
    logic [ADDR_W:0]   cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              cpu_rst_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;

    logic is_end;
    logic at_last;

    assign is_end  = (in_data == END_WORD);
    assign at_last = (addr_q == ADDR_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            // write strobe is a single-cycle pulse unless re-armed below
            we_q <= 1'b0;
            case (state_q)
                IDLE, RUN: begin
                    if (start) begin
                        state_q   <= LOAD;
                        addr_q    <= '0;
                        cnt_q     <= '0;
                        done_q    <= 1'b0;
                        ovf_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        cpu_rst_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        we_q    <= 1'b1;
                        waddr_q <= addr_q;
                        wdata_q <= in_data;
                        addr_q  <= addr_q + ADDR_ONE;   // wraps to 0 after the last word
                        cnt_q   <= cnt_q + CNT_ONE;
                        if (is_end || at_last) begin
                            ovf_q <= !is_end;
`ifdef IMEM_LOADER_PAD_EN
                            // a terminator at the last address leaves nothing to pad
                            if (is_end && !at_last) begin
                                state_q <= PAD;
                            end else begin
                                state_q   <= RUN;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                cpu_rst_q <= 1'b0;
                            end
`else
                            state_q   <= RUN;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_PAD_EN
                PAD: begin
                    we_q    <= 1'b1;
                    waddr_q <= addr_q;
                    wdata_q <= END_WORD;
                    addr_q  <= addr_q + ADDR_ONE;
                    if (at_last) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        cpu_rst_q <= 1'b0;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == LOAD);
    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: three instances (ADDR_W 8/3/4) share clock, reset and
// the source bus; each has its own start. A list-based model predicts the
// sequence of memory writes, final word count and overflow for each program.
module tb_imem_loader;
    localparam logic [31:0] END_W  = 32'hFFFF_FFFF;
    localparam logic [31:0] PROG_W = 32'h0082_1020;
`ifdef IMEM_LOADER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic        clk, rst, in_valid;
    logic [31:0] in_data;
    logic [2:0]  start;
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rdy, a_we, a_cpu, a_busy, a_done, a_ovf;
    logic [7:0] a_addr; logic [31:0] a_wd; logic [8:0] a_wc;
    logic b_rdy, b_we, b_cpu, b_busy, b_done, b_ovf;
    logic [2:0] b_addr; logic [31:0] b_wd; logic [3:0] b_wc;
    logic c_rdy, c_we, c_cpu, c_busy, c_done, c_ovf;
    logic [3:0] c_addr; logic [31:0] c_wd; logic [4:0] c_wc;

    imem_loader u_a (.clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_rdy), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wd), .cpu_rst(a_cpu),
        .busy(a_busy), .done(a_done), .overflow(a_ovf), .word_count(a_wc));
    imem_loader #(.ADDR_W(3)) u_b (.clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_rdy), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wd), .cpu_rst(b_cpu),
        .busy(b_busy), .done(b_done), .overflow(b_ovf), .word_count(b_wc));
    imem_loader #(.ADDR_W(4)) u_c (.clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid), .in_data(in_data),
        .in_ready(c_rdy), .imem_we(c_we), .imem_addr(c_addr), .imem_wdata(c_wd), .cpu_rst(c_cpu),
        .busy(c_busy), .done(c_done), .overflow(c_ovf), .word_count(c_wc));

    // uniform per-instance views
    logic rdy_v[3], we_v[3], cpu_v[3], busy_v[3], done_v[3], ovf_v[3];
    int   addr_v[3], wc_v[3];
    logic [31:0] wd_v[3];
    always_comb begin
        rdy_v[0] = a_rdy; we_v[0] = a_we; cpu_v[0] = a_cpu; busy_v[0] = a_busy; done_v[0] = a_done;
        ovf_v[0] = a_ovf; addr_v[0] = int'(a_addr); wc_v[0] = int'(a_wc); wd_v[0] = a_wd;
        rdy_v[1] = b_rdy; we_v[1] = b_we; cpu_v[1] = b_cpu; busy_v[1] = b_busy; done_v[1] = b_done;
        ovf_v[1] = b_ovf; addr_v[1] = int'(b_addr); wc_v[1] = int'(b_wc); wd_v[1] = b_wd;
        rdy_v[2] = c_rdy; we_v[2] = c_we; cpu_v[2] = c_cpu; busy_v[2] = c_busy; done_v[2] = c_done;
        ovf_v[2] = c_ovf; addr_v[2] = int'(c_addr); wc_v[2] = int'(c_wc); wd_v[2] = c_wd;
    end

    typedef struct { int addr; logic [31:0] data; } wr_t;
    wr_t         act_q[$];
    wr_t         exp_q[$];
    logic [31:0] prog_q[$];
    int sel = 0, lat_err = 0, spur = 0, m_cnt = 0, n_acc = 0;
    bit prev_acc = 1'b0, term_seen = 1'b0, m_ovf = 1'b0, fin = 1'b0;

    // write monitor: collects writes of the selected instance, checks that a
    // write follows every acceptance (pad writes only after a terminator),
    // and that idle instances never write
    always @(negedge clk) begin
        wr_t w;
        if (we_v[sel]) begin
            w.addr = addr_v[sel];
            w.data = wd_v[sel];
            act_q.push_back(w);
        end
        if (prev_acc && !we_v[sel]) lat_err++;
        if (we_v[sel] && !prev_acc && !term_seen) lat_err++;
        for (int i = 0; i < 3; i++) if (i != sel && we_v[i]) spur++;
        prev_acc = in_valid && rdy_v[sel];
        if (prev_acc && in_data == END_W) term_seen = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] rnd_word();
        logic [31:0] w = $urandom;
        if (w == END_W) w = 32'h0;
        return w;
    endfunction

    // expected write list from the program: words land at 0,1,2..., the load
    // stops at the terminator or after the last address; optional END_W fill
    task automatic model(input int aw);
        int  depth = 1 << aw;
        int  a = 0;
        bit  term = 1'b0;
        wr_t w;
        exp_q.delete(); m_cnt = 0; m_ovf = 1'b0;
        foreach (prog_q[i]) begin
            w.addr = a; w.data = prog_q[i];
            exp_q.push_back(w);
            m_cnt++;
            if (prog_q[i] == END_W) begin term = 1'b1; break; end
            if (a == depth - 1) begin m_ovf = 1'b1; break; end
            a++;
        end
        if (PAD_EN && term)
            for (int p = a + 1; p < depth; p++) begin
                w.addr = p; w.data = END_W;
                exp_q.push_back(w);
            end
    endtask

    function automatic int first_diff();
        int n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (act_q[i].addr != exp_q[i].addr || act_q[i].data !== exp_q[i].data) return i;
        if (act_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic pulse_start(input int d);
        sel = d; act_q.delete(); lat_err = 0; spur = 0; prev_acc = 1'b0; term_seen = 1'b0;
        @(posedge clk); #1 start[d] = 1'b1;
        @(posedge clk); #1 start[d] = 1'b0;
    endtask

    // offer prog_q with valid pattern mode (0 always, 1 alternate, 2 random)
    task automatic run_load(input int d, input int mode, input int stop_at, input int poke_at);
        int cyc = 0;
        bit v;
        n_acc = 0;
        while (rdy_v[d] && n_acc < prog_q.size() && n_acc != stop_at && cyc < 2000) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (cyc % 2 == 0);
            else v = 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = v ? prog_q[n_acc] : rnd_word();
            start[d] = (n_acc == poke_at);
            @(posedge clk); #1;
            if (v) n_acc++;
            cyc++;
        end
        in_valid = 1'b0; start[d] = 1'b0;
        fin = 1'b0;
        if (stop_at >= 0) return;
        cyc = 0;
        while (!done_v[d] && cyc < 600) begin @(posedge clk); #1; cyc++; end
        fin = done_v[d];
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_program(input string tag, input int d, input int mode, input int poke_at);
        int aw = (d == 0) ? 8 : (d == 1) ? 3 : 4;
        int fd;
        model(aw);
        pulse_start(d);
        checks++;
        if ({busy_v[d], cpu_v[d], rdy_v[d], done_v[d], ovf_v[d]} !== 5'b11100 || wc_v[d] !== 0) begin
            errors++;
            $display("FAIL %s_entry: busy,cpu_rst,in_ready,done,overflow=%b count=%0d, expected 11100 count=0",
                     tag, {busy_v[d], cpu_v[d], rdy_v[d], done_v[d], ovf_v[d]}, wc_v[d]);
        end
        run_load(d, mode, -1, poke_at);
        fd = first_diff();
        checks++;
        if (fin !== 1'b1) begin errors++; $display("FAIL %s_done: done=%b, expected 1", tag, fin); end
        checks++;
        if (fd !== -1) begin
            errors++;
            $display("FAIL %s_writes: first difference at write %0d, got %0d writes, expected %0d",
                     tag, fd, act_q.size(), exp_q.size());
        end
        checks++;
        if (wc_v[d] !== m_cnt) begin errors++; $display("FAIL %s_count: got %0d expected %0d", tag, wc_v[d], m_cnt); end
        checks++;
        if (ovf_v[d] !== m_ovf) begin errors++; $display("FAIL %s_overflow: got %b expected %b", tag, ovf_v[d], m_ovf); end
        checks++;
        if ({busy_v[d], rdy_v[d], cpu_v[d]} !== 3'b000) begin
            errors++; $display("FAIL %s_run: busy,in_ready,cpu_rst=%b expected 000", tag, {busy_v[d], rdy_v[d], cpu_v[d]});
        end
        checks++;
        if (n_acc !== m_cnt) begin errors++; $display("FAIL %s_accepted: got %0d expected %0d", tag, n_acc, m_cnt); end
        checks++;
        if (lat_err !== 0 || spur !== 0) begin
            errors++; $display("FAIL %s_timing: latency errors %0d stray writes %0d, expected 0 and 0", tag, lat_err, spur);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #3;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({cpu_v[d], rdy_v[d], we_v[d], busy_v[d], done_v[d], ovf_v[d]} !== 6'b100000 ||
                addr_v[d] !== 0 || wd_v[d] !== 32'h0 || wc_v[d] !== 0) begin
                errors++;
                $display("FAIL reset_%0d: cpu_rst,in_ready,we,busy,done,overflow=%b addr=%0d wdata=%h count=%0d, expected 100000 0 0 0",
                         d, {cpu_v[d], rdy_v[d], we_v[d], busy_v[d], done_v[d], ovf_v[d]}, addr_v[d], wd_v[d], wc_v[d]);
            end
        end
        #8 rst = 1'b1;
    endtask

    task automatic test_basic();
        prog_q.delete();
        repeat (7) prog_q.push_back(PROG_W);
        prog_q.push_back(END_W);
        test_program("basic", 0, 0, -1);
    endtask

    task automatic test_gapped();
        prog_q.delete();
        repeat (7) prog_q.push_back(PROG_W);
        prog_q.push_back(END_W);
        test_program("gapped", 0, 1, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            int n = $urandom_range(1, 20);
            prog_q.delete();
            repeat (n) prog_q.push_back(rnd_word());
            prog_q.push_back(END_W);
            test_program("random", 0, 2, -1);
        end
    endtask

    task automatic test_ignore();
        sel = 0; act_q.delete(); prev_acc = 1'b0; term_seen = 1'b0;
        repeat (8) begin
            in_valid = 1'b1; in_data = rnd_word();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (act_q.size() !== 0 || wc_v[0] !== m_cnt || done_v[0] !== 1'b1 || rdy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL ignore_run: writes=%0d count=%0d done=%b in_ready=%b, expected 0 %0d 1 0",
                     act_q.size(), wc_v[0], done_v[0], rdy_v[0], m_cnt);
        end
    endtask

    task automatic test_overflow();
        prog_q.delete();
        repeat (10) prog_q.push_back(rnd_word());
        test_program("overflow", 1, 2, -1);
    endtask

    task automatic test_term_last();
        prog_q.delete();
        repeat (7) prog_q.push_back(rnd_word());
        prog_q.push_back(END_W);
        test_program("term_last", 1, 0, -1);
    endtask

    task automatic test_pad();
        prog_q.delete();
        repeat (3) prog_q.push_back(rnd_word());
        prog_q.push_back(END_W);
        test_program("pad", 2, 0, -1);
    endtask

    task automatic test_start_busy();
        prog_q.delete();
        repeat (5) prog_q.push_back(rnd_word());
        prog_q.push_back(END_W);
        test_program("start_busy", 2, 2, 2);
    endtask

    task automatic test_reset_midload();
        prog_q.delete();
        repeat (10) prog_q.push_back(rnd_word());
        prog_q.push_back(END_W);
        pulse_start(0);
        run_load(0, 0, 3, -1);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({cpu_v[0], rdy_v[0], we_v[0], busy_v[0], done_v[0]} !== 5'b10000 || wc_v[0] !== 0 || addr_v[0] !== 0) begin
            errors++;
            $display("FAIL midload_reset: cpu_rst,in_ready,we,busy,done=%b count=%0d addr=%0d, expected 10000 0 0",
                     {cpu_v[0], rdy_v[0], we_v[0], busy_v[0], done_v[0]}, wc_v[0], addr_v[0]);
        end
        @(negedge clk); #1;
        checks++;
        if (act_q.size() !== 2 || act_q[0].addr !== 0 || act_q[0].data !== prog_q[0] ||
            act_q[1].addr !== 1 || act_q[1].data !== prog_q[1]) begin
            errors++;
            $display("FAIL midload_partial: got %0d writes, expected 2 writes of words 0 and 1 at addr 0,1", act_q.size());
        end
        rst = 1'b1;
        test_program("reload", 0, 0, -1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; start = '0;
        test_reset();
        test_basic();
        test_gapped();
        test_random();
        test_ignore();
        test_overflow();
        test_term_last();
        test_pad();
        test_start_busy();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
